// File: rtl/seg_scan_scheduler_if.sv
// Load handshake between a display-value producer and the scan scheduler.
// The producer holds Load_Valid and its data until Load_Ready is seen high.
interface seg_scan_scheduler_if;
  logic        Load_Valid;
  logic [31:0] Load_Value;
  logic [7:0]  Load_Mask;
  logic        Load_Ready;

  modport master (
    output Load_Valid,
    output Load_Value,
    output Load_Mask,
    input  Load_Ready
  );

  modport slave (
    input  Load_Valid,
    input  Load_Value,
    input  Load_Mask,
    output Load_Ready
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Time-multiplexed scan sequencer for an 8-digit seven-segment controller.
// Steps a digit index at a fixed dwell rate and presents {blank, nibble, index}
// each cycle. New display values are staged in a shadow register and only
// committed at a frame boundary (or while idle), so no digit shows a torn value.
module seg_scan_scheduler #(
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Scan_En,
  seg_scan_scheduler_if.slave  load,
  output logic [31:0]          Seg_Display,
  output logic                 Frame_Done
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e            state_q;
  logic [CntW-1:0]   div_cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [31:0]       active_value_q;
  logic [7:0]        active_mask_q;
  logic [31:0]       shadow_value_q;
  logic [7:0]        shadow_mask_q;
  logic              pending_q;

  logic              dwell_end;
  logic              last_digit;
  logic              accept;
  logic [31:0]       seg_digit;

  assign load.Load_Ready = ~pending_q;

  // Dwell/frame boundary decode, handshake transfer and the word for the current digit.
  always_comb begin
    dwell_end  = (div_cnt_q == CntW'(CLK_DIV - 1));
    last_digit = (idx_q == IdxW'(NUM_DIGITS - 1));
    accept     = load.Load_Valid & ~pending_q;
    seg_digit  = 32'h0;
    seg_digit[IdxW-1:0] = idx_q;
    seg_digit[6:3]      = active_value_q[{idx_q, 2'b00} +: 4];
    seg_digit[7]        = ~active_mask_q[idx_q];
  end

  // Scan FSM with registered display word, frame pulse and shadow/commit bookkeeping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= StIdle;
      div_cnt_q      <= '0;
      idx_q          <= '0;
      active_value_q <= 32'h0;
      active_mask_q  <= 8'hFF;
      shadow_value_q <= 32'h0;
      shadow_mask_q  <= 8'h0;
      pending_q      <= 1'b0;
      Frame_Done     <= 1'b0;
      Seg_Display    <= 32'h0000_0080;
    end else begin
      Frame_Done <= 1'b0;

      // accept only fires with pending_q low, so it never collides with a commit
      if (accept) begin
        shadow_value_q <= load.Load_Value;
        shadow_mask_q  <= load.Load_Mask;
        pending_q      <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          div_cnt_q   <= '0;
          idx_q       <= '0;
          Seg_Display <= 32'h0000_0080;
          // nothing is on display, so a staged value can go live immediately
          if (pending_q) begin
            active_value_q <= shadow_value_q;
            active_mask_q  <= shadow_mask_q;
            pending_q      <= 1'b0;
          end
          if (Scan_En) begin
            state_q <= StScan;
          end
        end

        StScan: begin
          Seg_Display <= seg_digit;
          if (!Scan_En) begin
            // abandon the frame: no pulse, no commit
            state_q   <= StIdle;
            div_cnt_q <= '0;
            idx_q     <= '0;
          end else if (dwell_end) begin
            div_cnt_q <= '0;
            idx_q     <= idx_q + 1'b1;
            if (last_digit) begin
              Frame_Done <= 1'b1;
              if (pending_q) begin
                active_value_q <= shadow_value_q;
                active_mask_q  <= shadow_mask_q;
                pending_q      <= 1'b0;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench for seg_scan_scheduler with a short dwell (CLK_DIV = 4).
// Expected per-cycle display words are queued when stimulus is applied and
// compared one per clock by the monitor.
module tb_seg_scan_scheduler;

  localparam int unsigned ClkDiv = 4;

  logic        Clk;
  logic        Reset;
  logic        Scan_En;
  logic [31:0] Seg_Display;
  logic        Frame_Done;

  seg_scan_scheduler_if lif ();

  seg_scan_scheduler #(
    .CLK_DIV    (ClkDiv),
    .NUM_DIGITS (8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Scan_En     (Scan_En),
    .load        (lif),
    .Seg_Display (Seg_Display),
    .Frame_Done  (Frame_Done)
  );

  typedef struct packed {
    logic [31:0] seg;
    logic        fd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   nidx     = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] digit_word(input logic [31:0] v, input logic [7:0] m,
                                             input int k);
    logic [31:0] w;
    w      = 32'h0;
    w[2:0] = k[2:0];
    w[6:3] = v[4*k +: 4];
    w[7]   = ~m[k];
    return w;
  endfunction

  // Queue n cycles of a frame showing value v with mask m (32 entries = full frame).
  task automatic push_frame(input logic [31:0] v, input logic [7:0] m, input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.seg = digit_word(v, m, j / ClkDiv);
      e.fd  = (j == 8 * ClkDiv - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.seg = 32'h0000_0080;
      e.fd  = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  // Advance to the negedge following scan edge t (edge 0 = IDLE->SCAN edge).
  task automatic goto(input int t);
    while (nidx < t) begin
      @(negedge Clk);
      nidx++;
    end
  endtask

  // Monitor: one scoreboard entry per clock, sampled just after the edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("seg", Seg_Display, e.seg);
      check("frame_done", 32'(Frame_Done), 32'(e.fd));
    end
  end

  initial begin
    Reset          = 1'b1;
    Scan_En        = 1'b0;
    lif.Load_Valid = 1'b0;
    lif.Load_Value = 32'h0;
    lif.Load_Mask  = 8'h0;

    repeat (2) @(negedge Clk);
    check("rst_seg", Seg_Display, 32'h0000_0080);
    check("rst_ready", 32'(lif.Load_Ready), 32'd1);
    check("rst_fd", 32'(Frame_Done), 32'd0);
    Reset = 1'b0;

    // Idle: blanked digit 0, no pulses
    push_idle(8);
    repeat (8) @(negedge Clk);
    check("idle_ready", 32'(lif.Load_Ready), 32'd1);

    // Load while idle; it commits on the next idle cycle
    lif.Load_Valid = 1'b1;
    lif.Load_Value = 32'h7654_3210;
    lif.Load_Mask  = 8'hFF;
    @(negedge Clk);
    check("idle_pending", 32'(lif.Load_Ready), 32'd0);
    lif.Load_Valid = 1'b0;
    @(negedge Clk);
    check("idle_commit_ready", 32'(lif.Load_Ready), 32'd1);
    Scan_En = 1'b1;
    @(negedge Clk);
    nidx = 0;
    check("scan_start_seg", Seg_Display, 32'h0000_0080);
    push_frame(32'h7654_3210, 8'hFF, 32);
    push_frame(32'h7654_3210, 8'hFF, 32);

    // Mid-frame load at digit 3 of frame 1: held until the frame boundary
    goto(45);
    lif.Load_Valid = 1'b1;
    lif.Load_Value = 32'hFEDC_BA98;
    lif.Load_Mask  = 8'hFF;
    push_frame(32'hFEDC_BA98, 8'hFF, 32);
    goto(46);
    check("mid_busy", 32'(lif.Load_Ready), 32'd0);
    lif.Load_Valid = 1'b0;
    lif.Load_Value = 32'hDEAD_BEEF;   // ignored: not a transfer
    goto(63);
    check("mid_busy_late", 32'(lif.Load_Ready), 32'd0);
    goto(64);
    check("mid_rerdy", 32'(lif.Load_Ready), 32'd1);

    // Load on the exact boundary cycle: old value shown one more frame
    goto(95);
    lif.Load_Valid = 1'b1;
    lif.Load_Value = 32'h0F1E_2D3C;
    lif.Load_Mask  = 8'hAA;
    push_frame(32'hFEDC_BA98, 8'hFF, 32);
    push_frame(32'h0F1E_2D3C, 8'hAA, 32);
    push_frame(32'h0F1E_2D3C, 8'hAA, 21);
    goto(96);
    check("bnd_busy", 32'(lif.Load_Ready), 32'd0);
    lif.Load_Valid = 1'b0;
    goto(127);
    check("bnd_busy_late", 32'(lif.Load_Ready), 32'd0);
    goto(128);
    check("bnd_rerdy", 32'(lif.Load_Ready), 32'd1);

    // Stage another load, then reset mid-dwell at digit 5 with it pending
    goto(165);
    lif.Load_Valid = 1'b1;
    lif.Load_Value = 32'h3333_4444;
    lif.Load_Mask  = 8'h00;
    goto(166);
    lif.Load_Valid = 1'b0;
    goto(180);
    check("pre_rst_busy", 32'(lif.Load_Ready), 32'd0);
    goto(181);
    Reset = 1'b1;
    #1;
    check("async_rst_seg", Seg_Display, 32'h0000_0080);
    check("async_rst_fd", 32'(Frame_Done), 32'd0);
    check("async_rst_ready", 32'(lif.Load_Ready), 32'd1);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_seg", Seg_Display, 32'h0000_0080);
    check("post_rst_ready", 32'(lif.Load_Ready), 32'd1);
    // Shadow was discarded: a frame of zeros with all digits enabled
    push_frame(32'h0, 8'hFF, 32);
    repeat (32) @(negedge Clk);
    check("post_rst_ready2", 32'(lif.Load_Ready), 32'd1);

    // Scan off: back to blanked digit 0
    Scan_En = 1'b0;
    repeat (3) @(negedge Clk);
    check("stop_seg", Seg_Display, 32'h0000_0080);
    check("stop_fd", 32'(Frame_Done), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
- Time-multiplexed scan sequencer for the 8-digit seven-segment controller.
- Holds a 32-bit display value (eight hex nibbles) and steps a digit index at a programmable dwell rate.
- Drives the controller's Seg_Display word each cycle: bits [2:0] carry the digit index, bits [6:3] carry the nibble.
- New values arrive over a valid/ready handshake and are committed only at frame boundaries, so a digit never shows a half-updated value.

Parameters:
- CLK_DIV, 100000, clock cycles each digit is held (dwell); legal range >= 2.
- NUM_DIGITS, 8, digits per frame; fixed at 8 (index width 3).

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Scan_En  input  1  1 = scanning; 0 = hold at digit 0, blanked.
- Load_Valid  input  1  new display value offered.
- Load_Value  input  32  eight nibbles; digit k = bits [4k+3:4k].
- Load_Mask  input  8  per-digit enable; bit k = 1 shows digit k.
- Load_Ready  output  1  scheduler can accept a load.
- Seg_Display  output  32  to controller: [2:0] index, [6:3] nibble, [7] blank flag, [31:8] zero.
- Frame_Done  output  1  one-cycle pulse when digit 7 dwell ends.

Behaviour:
- Reset (async, Reset=1): div_cnt=0, idx=0, active_value=0, active_mask=8'hFF, pending=0, Load_Ready=1, Frame_Done=0, Seg_Display=32'h0000_0080.
- States:
  - IDLE (Scan_En=0): div_cnt=0, idx=0, Seg_Display=32'h80.
  - SCAN (Scan_En=1).
  - IDLE->SCAN on the first cycle Scan_En=1; counting starts at div_cnt=0 with digit 0.
  - SCAN->IDLE on the cycle after Scan_En=0; this aborts the frame, no Frame_Done.
- Dwell counter: in SCAN, div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it returns to 0 and idx advances mod 8. Each digit is therefore held exactly CLK_DIV cycles.
- Frame boundary is the cycle with div_cnt=CLK_DIV-1 and idx=7. On that cycle:
  - idx -> 0.
  - Frame_Done=1 on the next cycle, for 1 cycle.
  - If pending=1: active_value/active_mask <= shadow, pending <= 0.
- Output register: Seg_Display is registered from the current idx and active registers, so it lags idx by 1 cycle.
  - Seg_Display[6:3] = active_value nibble[idx].
  - Seg_Display[2:0] = idx.
  - Seg_Display[7] = ~active_mask[idx].
  - A blanked digit still consumes its dwell; the order is never reordered or skipped.
- Handshake:
  - Load_Ready = ~pending.
  - Transfer occurs when Load_Valid & Load_Ready at a rising edge: shadow <= {Load_Value, Load_Mask}, pending <= 1.
  - Load_Value/Load_Mask are ignored while Load_Ready=0; the requester must hold Valid.
- Simultaneous transfer and frame boundary: the commit uses the pending state from before the edge. A load accepted on the boundary cycle commits at the following boundary.
- Commit then re-accept: pending clears on the commit edge, and Load_Ready rises in the next cycle.
- IDLE commit: a pending load is committed on the first IDLE cycle (no boundary needed), with no Frame_Done.
- Reset mid-frame or mid-handshake discards the shadow and the pending flag; the requester must re-offer.
- Width rules: div_cnt width is clog2(CLK_DIV); idx is 3 bits and wraps 7->0 naturally; bits [31:8] of Seg_Display are tied 0.

Test Plan (CLK_DIV=4 in bench):
- Reset then Scan_En=0 -> Seg_Display=32'h80, Load_Ready=1, Frame_Done=0 indefinitely.
- Load 32'h7654_3210, mask FF while idle, then Scan_En=1 -> Seg_Display[6:0] steps {0,0},{1,1}..{7,7}, 4 cycles each. Frame_Done pulses every 32 cycles, 1 cycle after digit 7 dwell ends.
- While scanning 32'h7654_3210, load 32'hFEDC_BA98 at digit 3 -> Load_Ready=0 until the boundary. Digits 3..7 still show 3..7; the next frame shows 8..F; Load_Ready returns 1 one cycle after the commit.
- Load accepted on the exact boundary cycle -> the old value is shown for one more full frame, then the new value.
- Mask 8'b1010_1010 -> digits 0,2,4,6 present Seg_Display[7]=1, each still for 4 cycles; odd digits have [7]=0.
- Assert Reset asynchronously mid-dwell at digit 5 with pending=1 -> outputs return to reset values immediately (before the next edge). After release, active_value=0 and Load_Ready=1.
